// File: rtl/pixel_mixer.sv
// pixel_mixer: final PPU pixel stage. Pops the background FIFO, merges the sprite FIFO head,
// applies BGP/OBP0/OBP1 and emits shaded pixels with screen coordinates.
//
// state   | meaning
// IDLE    | waiting for line_start_in
// DISCARD | dropping the SCX%8 leading background pixels
// DRAW    | popping, mixing and emitting visible pixels
// DONE    | line finished; line_done_out pulses as we return to IDLE
module pixel_mixer #(
    parameter int X_MAX           = 160,
    parameter int TOTAL_SCANLINES = 154
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               tclk_in,
    input  logic                               line_start_in,
    input  logic [$clog2(TOTAL_SCANLINES)-1:0] Y_in,
    input  logic [7:0]                         SCX_in,
    input  logic [7:0]                         BGP_in,
    input  logic [7:0]                         OBP0_in,
    input  logic [7:0]                         OBP1_in,
    input  logic                               bg_ena_in,
    input  logic                               obj_ena_in,
    input  logic [1:0]                         bg_pixel_in,
    input  logic                               bg_valid_in,
    output logic                               bg_rd_en_out,
    input  logic [1:0]                         obj_pixel_in,
    input  logic                               obj_palette_in,
    input  logic                               obj_priority_in,
    input  logic                               obj_valid_in,
    output logic                               obj_rd_en_out,
    input  logic                               stall_in,
    output logic [$clog2(X_MAX)-1:0]           X_out,
    output logic [1:0]                         pixel_out,
    output logic [$clog2(X_MAX)-1:0]           pixel_x_out,
    output logic [$clog2(TOTAL_SCANLINES)-1:0] pixel_y_out,
    output logic                               pixel_valid_out,
    output logic                               line_done_out,
    output logic                               busy_out
);
    localparam int XW = $clog2(X_MAX);
    localparam int YW = $clog2(TOTAL_SCANLINES);

    typedef enum logic [1:0] {IDLE, DISCARD, DRAW, DONE} state_t;

    state_t         state;
    logic [2:0]     fine;
    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic           active;
    logic           step;
    logic [1:0]     bg_color;
    logic [1:0]     color;
    logic [1:0]     shade;
    logic           obj_win;
    logic [7:0]     palette;
    logic           unused_scx;

    assign unused_scx = ^SCX_in[7:3];

    // A restart request wins over popping in the same cycle.
    assign active        = (state == DISCARD) || (state == DRAW);
    assign step          = tclk_in && bg_valid_in && !stall_in && active && !line_start_in;
    assign bg_rd_en_out  = step;
    assign obj_rd_en_out = step && (state == DRAW) && obj_valid_in;
    assign busy_out      = active;
    assign X_out         = x;

    always_comb begin
        bg_color = bg_ena_in ? bg_pixel_in : 2'd0;
        obj_win  = obj_ena_in && obj_valid_in && (obj_pixel_in != 2'd0)
                   && !(obj_priority_in && (bg_color != 2'd0));
        color    = obj_win ? obj_pixel_in : bg_color;
        palette  = obj_win ? (obj_palette_in ? OBP1_in : OBP0_in) : BGP_in;
        shade    = palette[{color, 1'b0} +: 2];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state           <= IDLE;
            fine            <= 3'd0;
            x               <= '0;
            y               <= '0;
            pixel_out       <= 2'd0;
            pixel_x_out     <= '0;
            pixel_y_out     <= '0;
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
        end else begin
            pixel_valid_out <= 1'b0;
            line_done_out   <= 1'b0;
            if (line_start_in) begin
                fine  <= SCX_in[2:0];
                x     <= '0;
                y     <= Y_in;
                state <= (SCX_in[2:0] != 3'd0) ? DISCARD : DRAW;
            end else begin
                case (state)
                    IDLE: ;
                    DISCARD: begin
                        if (step) begin
                            fine <= fine - 3'd1;
                            if (fine == 3'd1) state <= DRAW;
                        end
                    end
                    DRAW: begin
                        if (step) begin
                            pixel_out       <= shade;
                            pixel_x_out     <= x;
                            pixel_y_out     <= y;
                            pixel_valid_out <= 1'b1;
                            if (x == XW'(X_MAX - 1)) state <= DONE;
                            else                     x     <= x + 1'b1;
                        end
                    end
                    DONE: begin
                        line_done_out <= 1'b1;
                        state         <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
